multicast_scheduler: RTL
========================

MULTICAST_SCHEDULER -- requirements
Module: multicast_scheduler

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of job_len; beats per caster = job_len+1 (1..2^LEN_W).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: COMPUTE watchdog limit, used only with MCS_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port job_valid, input, 1: a job is offered.
REQ-006 SHALL have port job_ready, output, 1: the scheduler accepts a job.
REQ-007 SHALL have port job_mask, input, 3: casters to load; bit0 ifmap, bit1 fltr, bit2 psum.
REQ-008 SHALL have port job_len, input, LEN_W: beats-per-caster minus one.
REQ-009 SHALL have port caster_en, output, 3: one-hot enable to the multicaster CASTER_EN bus.
REQ-010 SHALL have port caster_ready, input, 1: the multicaster accepts the current beat.
REQ-011 SHALL have port caster_valid, input, 1: the multicaster reports the computation done.
REQ-012 SHALL have port pe_start, output, 1: single-cycle start pulse to the PEs.
REQ-013 SHALL have port busy, output, 1: the FSM is not in IDLE.
REQ-014 SHALL have port done, output, 1: single-cycle job-complete pulse.
REQ-015 SHALL have port err_timeout, output, 1: watchdog fired; valid together with done.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, COMPUTE, DONE; all outputs registered.
REQ-017 IDLE: job_ready=1; on job_valid&job_ready, SHALL latch mask/len, clear beat counter, go LOAD; mask==0 goes directly to DONE with no pe_start.
REQ-018 LOAD: caster_en SHALL be one-hot on the lowest set bit of the remaining mask; job_ready=0.
REQ-019 A beat SHALL transfer only in a cycle where caster_en is nonzero and caster_ready=1; the beat counter increments per beat.
REQ-020 On the final beat (count==len) SHALL clear that mask bit, reset the counter, and switch caster_en to the next caster the following cycle with no idle bubble.
REQ-021 Final beat of the last caster SHALL give caster_en=0 and enter COMPUTE next cycle.
REQ-022 The cycle after entering COMPUTE, pe_start SHALL pulse exactly once per job.
REQ-023 COMPUTE SHALL go to DONE on the first cycle caster_valid=1 after pe_start; caster_valid at or before the pe_start cycle is ignored.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE; the next job can be accepted the cycle after.
REQ-025 caster_ready low in LOAD SHALL hold caster_en and the counter unchanged, indefinitely.
REQ-026 job_mask/job_len changes after acceptance SHALL have no effect on the running job.

Reset
REQ-027 rstn=0 at a clock edge SHALL force IDLE and set caster_en=0, pe_start=0, done=0, busy=0, err_timeout=0, counters=0; job_ready=1 from the first cycle after reset.
REQ-028 Reset mid-LOAD or mid-COMPUTE SHALL abandon the job silently, with no done pulse.

Configuration
REQ-029 With macro MCS_TIMEOUT_EN defined, a counter SHALL run in COMPUTE; after TIMEOUT_CYCLES cycles without caster_valid, go to DONE with done=1 and err_timeout=1 in that cycle.
REQ-030 Without MCS_TIMEOUT_EN, COMPUTE SHALL wait indefinitely, err_timeout SHALL be tied 0, and no watchdog logic is built.

Verification
REQ-031 mask=3'b111, len=1, caster_ready=1 -> caster_en 001,001,010,010,100,100 on consecutive cycles; pe_start next; done after caster_valid.
REQ-032 mask=3'b101, len=0, caster_ready toggling 1/0 -> only 001 then 100 asserted; caster_en holds through ready-low cycles; exactly 2 beats.
REQ-033 mask=3'b000 -> done one cycle after acceptance; caster_en and pe_start never asserted.
REQ-034 rstn=0 during the 2nd fltr beat -> next cycle caster_en=0, busy=0, job_ready=1; no done pulse.
REQ-035 MCS_TIMEOUT_EN, TIMEOUT_CYCLES=16, caster_valid held 0 -> done=1 and err_timeout=1 together, 16 cycles after pe_start.
REQ-036 caster_valid=1 throughout LOAD -> no early COMPUTE exit; done one cycle after the first caster_valid following pe_start.

Source files
------------

// File: rtl/multicast_scheduler_if.sv
// Purpose: handshake/status bundle between a job source and the multicast scheduler.
// Latency: none; this file only groups wires.
// Backpressure: job_valid/job_ready for jobs; caster_ready stalls individual beats.
// Ports: job_* carry job offers; caster_* and pe_start face the multicaster and PEs;
//        busy/done/err_timeout report status. master = job source/environment, slave = scheduler.
interface multicast_scheduler_if #(
  parameter int LEN_W = 8
);
  logic             job_valid;
  logic             job_ready;
  logic [2:0]       job_mask;
  logic [LEN_W-1:0] job_len;
  logic [2:0]       caster_en;
  logic             caster_ready;
  logic             caster_valid;
  logic             pe_start;
  logic             busy;
  logic             done;
  logic             err_timeout;

  modport master (
    output job_valid, job_mask, job_len, caster_ready, caster_valid,
    input  job_ready, caster_en, pe_start, busy, done, err_timeout
  );

  modport slave (
    input  job_valid, job_mask, job_len, caster_ready, caster_valid,
    output job_ready, caster_en, pe_start, busy, done, err_timeout
  );
endinterface

// File: rtl/multicast_scheduler.sv
// Purpose: sequences a job through the ifmap/fltr/psum multicasters, starts the PEs, waits for completion.
// Latency: first caster_en one cycle after acceptance; done one cycle after the first caster_valid following pe_start.
// Backpressure: caster_ready low freezes caster_en and the beat counter; job_ready is high only in IDLE.
// Ports: clk, rstn (synchronous, active-low); bus (slave modport of multicast_scheduler_if).
// Option: define MCS_TIMEOUT_EN to build the COMPUTE watchdog (TIMEOUT_CYCLES); otherwise err_timeout is 0.
module multicast_scheduler #(
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  multicast_scheduler_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       mask_q, mask_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             job_ready_q, job_ready_d;
  logic [2:0]       caster_en_q, caster_en_d;
  logic             pe_start_q, pe_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             beat, last_beat;
  logic             tmo_fire;

`ifdef MCS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  function automatic logic [2:0] lowest_bit(input logic [2:0] m);
    return {m[2] & ~m[1] & ~m[0], m[1] & ~m[0], m[0]};
  endfunction

  // caster_en is only nonzero in LOAD, so it doubles as the "loading" qualifier.
  assign beat      = (caster_en_q != 3'b000) && bus.caster_ready;
  assign last_beat = beat && (cnt_q == len_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mask_q      <= 3'b000;
      len_q       <= '0;
      cnt_q       <= '0;
      job_ready_q <= 1'b1;
      caster_en_q <= 3'b000;
      pe_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MCS_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      job_ready_q <= job_ready_d;
      caster_en_q <= caster_en_d;
      pe_start_q  <= pe_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MCS_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    tmo_fire = 1'b0;
`ifdef MCS_TIMEOUT_EN
    tmo_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.job_valid && job_ready_q) begin
          mask_d  = bus.job_mask;
          len_d   = bus.job_len;
          cnt_d   = '0;
          state_d = (bus.job_mask == 3'b000) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (last_beat) begin
          mask_d = mask_q & ~caster_en_q;
          cnt_d  = '0;
          if (mask_d == 3'b000) state_d = COMPUTE;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMPUTE: begin
        // pe_start_q marks the first COMPUTE cycle; a completion seen there is stale.
        if (bus.caster_valid && !pe_start_q) begin
          state_d = DONE;
`ifdef MCS_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: outputs are registered, so they are computed from the next state.
  always_comb begin
    job_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    caster_en_d = (state_d == LOAD) ? lowest_bit(mask_d) : 3'b000;
    pe_start_d  = (state_q == LOAD) && (state_d == COMPUTE);
    done_d      = (state_d == DONE);
`ifdef MCS_TIMEOUT_EN
    err_d       = tmo_fire;
`endif
  end

  assign bus.job_ready = job_ready_q;
  assign bus.caster_en = caster_en_q;
  assign bus.pe_start  = pe_start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef MCS_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
  logic unused_tmo;
  assign unused_tmo = tmo_fire;
`endif

endmodule
